// File: rtl/aes_plain_byte_stream.sv
// Byte-stream back end for the pipelined AES-128 decryptor.
// Optional macro ZERO_TO_SPACE_EN maps 8'h00 bytes to 8'h20 on byte_out.
module aes_plain_byte_stream #(
    parameter int LATENCY = 20,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic [7:0]   byte_out,
    output logic         byte_valid,
    input  logic         byte_ready,
    output logic         byte_last,
    output logic [15:0]  blk_count,
    output logic         drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t               state, state_n;
    logic [LATENCY-1:0]   vdl;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic [AW-1:0]        wptr, rptr;
    logic [127:0]         mem [DEPTH];
    logic [127:0]         sreg;
    logic [3:0]           idx;
    logic [CW:0]          credit_sum;
    logic                 acc, cap, empty;
    logic                 pop, adv, inc_blk;
    logic [7:0]           raw_byte;

    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready   = credit_sum < (CW+1)'(DEPTH);
    assign acc        = in_valid & in_ready;
    assign cap        = vdl[LATENCY-1];
    assign empty      = (fifo_count == '0);

    // Valid delay line marking which decryptor output cycles hold real blocks
    generate
        if (LATENCY == 1) begin : g_vdl1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vdl <= '0;
                else     vdl <= acc;
            end
        end else begin : g_vdln
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vdl <= '0;
                else     vdl <= {vdl[LATENCY-2:0], acc};
            end
        end
    endgenerate

    // Credit and occupancy counters, pointers and the sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= '0;
            fifo_count <= '0;
            wptr       <= '0;
            rptr       <= '0;
            drop_err   <= 1'b0;
        end else begin
            if (acc && !cap)      inflight <= inflight + CW'(1);
            else if (!acc && cap) inflight <= inflight - CW'(1);
            if (cap && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!cap && pop) fifo_count <= fifo_count - CW'(1);
            if (cap) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (in_valid && !in_ready) drop_err <= 1'b1;
        end
    end

    // Block storage, written when a tracked plaintext emerges
    always_ff @(posedge clk) begin
        if (cap) mem[wptr] <= plaintext;
    end

    // Serialiser next-state and pop/advance decisions
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        adv     = 1'b0;
        inc_blk = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_ready) begin
                    if (idx == 4'd15) begin
                        inc_blk = 1'b1;
                        if (!empty) pop = 1'b1;
                        else        state_n = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Serialiser state, shift register, byte index and block counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            idx       <= '0;
            blk_count <= '0;
        end else begin
            state <= state_n;
            if (pop) begin
                sreg <= mem[rptr];
                idx  <= '0;
            end else if (adv) begin
                sreg <= {sreg[119:0], 8'h00};
                idx  <= idx + 4'd1;
            end
            if (inc_blk) blk_count <= blk_count + 16'd1;
        end
    end

    assign raw_byte   = sreg[127:120];
    assign byte_valid = (state == SHIFT);
    assign byte_last  = byte_valid && (idx == 4'd15);

`ifdef ZERO_TO_SPACE_EN
    assign byte_out = !byte_valid ? 8'h00 :
                      (raw_byte == 8'h00) ? 8'h20 : raw_byte;
`else
    assign byte_out = byte_valid ? raw_byte : 8'h00;
`endif

endmodule

// File: doc/aes_plain_byte_stream.md
Name: aes_plain_byte_stream

Overview:
- Downstream consumer of the pipelined AES-128 decryptor (fixed LATENCY, no handshake, plaintext[127:0] out).
- Tracks which decryptor output cycles carry real blocks and captures them into a small FIFO.
- Serialises the blocks MSB-byte-first onto a valid/ready byte stream.
- Throttles the upstream ciphertext feeder with credit-based in_ready so no result is ever lost.

Parameters:
- LATENCY, 20, cycles from ciphertext sampled at posedge k to matching plaintext capturable at posedge k+LATENCY; must be ≥1.
- DEPTH, 4, FIFO depth in 128-bit blocks; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  high in the cycle the feeder presents a real ciphertext to the decryptor.
- in_ready  out  1  feeder may assert in_valid only when high.
- plaintext  in  128  decryptor output.
- byte_out  out  8  current byte.
- byte_valid  out  1  byte_out valid.
- byte_ready  in  1  sink accepts byte.
- byte_last  out  1  high with byte 15 (bits 7:0) of a block.
- blk_count  out  16  blocks fully emitted.
- drop_err  out  1  sticky; in_valid seen while in_ready low.

Behaviour:
- Reset values (async on rst=1): in_ready=1, byte_out=0, byte_valid=0, byte_last=0, blk_count=0, drop_err=0.
- Reset also clears the valid delay line, FIFO pointers/count, inflight counter and serialiser state. Decryptor outputs emerging after reset are never captured.
- Accept: in_valid & in_ready at posedge k shifts a 1 into a LATENCY-bit valid delay line and increments inflight.
- in_valid & !in_ready: the valid is not entered and drop_err sets.
- Capture: at posedge k+LATENCY, if the delayed bit is 1, plaintext is written to the FIFO and inflight decrements.
- in_ready = (inflight + fifo_count) < DEPTH, from registered values only. FIFO overflow is therefore impossible by construction.
- Simultaneous accept and capture: inflight unchanged.
- Simultaneous capture and pop: fifo_count unchanged.
- FIFO pointers: log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
- Serialiser FSM:
  - IDLE: byte_valid=0. If FIFO non-empty, pop the head into the 128-bit shift register, idx=0, go to SHIFT next cycle.
  - SHIFT: byte_valid=1, byte_out = bits[127-8*idx -: 8], byte_last=(idx==15). On a byte_valid & byte_ready handshake, idx++.
  - On the handshake with idx==15: blk_count++ (wraps 0xFFFF→0). If FIFO non-empty, pop and reload in the same cycle, idx=0, stay in SHIFT (no bubble). Otherwise go to IDLE.
- Sink stall: byte_out and byte_last stay stable while byte_valid & !byte_ready.
- byte_valid never deasserts without a handshake, except on reset.
- The FIFO slot is freed at pop, so one extra block can sit in the serialiser beyond DEPTH.
- Latency: a block captured at posedge c produces its first byte_valid at the output after posedge c+1 when the serialiser was idle.

Optional Feature:
- Macro ZERO_TO_SPACE_EN.
- Defined: any byte equal to 8'h00 is presented as 8'h20 on byte_out; all other bytes pass unchanged; blk_count and byte_last are unaffected.
- Undefined: bytes are presented raw.

Test Plan:
- Single block, byte_ready=1, LATENCY=20: in_valid at posedge 0, plaintext=54686500636f6d706c65786974790066 held at posedge 20.
  - Expected: first byte_valid after posedge 21, bytes 54 68 65 00 63 6f 6d 70 6c 65 78 69 74 79 00 66, byte_last on byte 66, blk_count=1.
  - With ZERO_TO_SPACE_EN, bytes 4 and 15 read 20 ("The complexity f").
- Back-to-back: 2 in_valid cycles with blocks 0 and 1 (6f72006d696e696d756d00636f6d706f), byte_ready=1.
  - Expected: 32 consecutive handshakes with no bubble, byte_last on the 16th and 32nd, blk_count=2.
- Credit throttling, DEPTH=4, byte_ready=0, in_valid held high 6 cycles.
  - Expected: in_ready falls after the 4th accept. The 5th cycle sets drop_err=1. Only 4 blocks are later emitted once byte_ready=1.
- Sink stall: byte_ready toggled 1,0,0,1 mid-block.
  - Expected: byte_out held during the 0 cycles, no byte skipped or duplicated, 16 bytes total.
- Reset mid-operation: 3 blocks accepted, rst pulsed at cycle 10, before any capture.
  - Expected: all outputs at reset values, no bytes emitted afterwards even though the decryptor still produces data.
  - Bench drives the active-low decryptor reset with ~rst.
- Wrap: DEPTH=4, 24-block stream (fed only while in_ready=1), random byte_ready.
  - Expected: bytes match the expected plaintext in order, blk_count=24, drop_err=0.
